// File: rtl/regfile_wb_if.sv
// Signal bundle between the core/multi-cycle unit and the register-file write-port scheduler.
// The master drives requests, sources and results. The slave returns stall, mc_ready and the write-port controls.
interface regfile_wb_if #(
    parameter int XLEN = 64
);
    logic            core_write;
    logic [4:0]      core_rd;
    logic [XLEN-1:0] core_data;
    logic            mc_issue;
    logic [4:0]      mc_issue_rd;
    logic            mc_valid;
    logic [4:0]      mc_rd;
    logic [XLEN-1:0] mc_data;
    logic            mc_ready;
    logic [4:0]      rs1_address;
    logic [4:0]      rs2_address;
    logic            stall;
    logic            rf_reg_write;
    logic [4:0]      rf_rd_address;
    logic [XLEN-1:0] rf_write_data;

    // Handshake: a result transfers on a rising edge where mc_valid && mc_ready are both high.
    // Core writes and issues take effect only in cycles where stall is low.
    modport master (
        output core_write, core_rd, core_data, mc_issue, mc_issue_rd,
               mc_valid, mc_rd, mc_data, rs1_address, rs2_address,
        input  mc_ready, stall, rf_reg_write, rf_rd_address, rf_write_data
    );

    modport slave (
        input  core_write, core_rd, core_data, mc_issue, mc_issue_rd,
               mc_valid, mc_rd, mc_data, rs1_address, rs2_address,
        output mc_ready, stall, rf_reg_write, rf_rd_address, rf_write_data
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between core writeback and buffered multi-cycle results.
// It also keeps a pending-write scoreboard and raises stall on hazards or when a result is starved.
module regfile_wb_scheduler #(
    parameter int XLEN         = 64,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    regfile_wb_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [31:0]     r_busy;
    logic [4:0]      r_buf_rd   [DEPTH];
    logic [XLEN-1:0] r_buf_data [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [CW-1:0]   r_starve_cnt;

    logic            w_empty;
    logic            w_full;
    logic            w_starve;
    logic            w_hazard;
    logic            w_stall;
    logic            w_cw;
    logic            w_pop;
    logic            w_push;
    logic            w_issue_ok;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_data;
    logic [31:0]     w_busy_next;
    logic            w_we;
    logic [4:0]      w_addr;
    logic [XLEN-1:0] w_data;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_starve    = (r_starve_cnt == CW'(STARVE_LIMIT));
    assign w_head_rd   = r_buf_rd[r_rd_ptr];
    assign w_head_data = r_buf_data[r_rd_ptr];

    assign w_hazard = (bus.rs1_address != 5'd0 && r_busy[bus.rs1_address])
                    | (bus.rs2_address != 5'd0 && r_busy[bus.rs2_address])
                    | (bus.core_write && bus.core_rd != 5'd0 && r_busy[bus.core_rd])
                    | (bus.mc_issue && bus.mc_issue_rd != 5'd0 && r_busy[bus.mc_issue_rd])
                    | w_starve;

    // Outputs are forced quiet while reset is held, even before the first edge clears state.
    assign w_stall    = !reset && w_hazard;
    assign w_cw       = !reset && bus.core_write && !w_stall && bus.core_rd != 5'd0;
    assign w_pop      = !reset && !w_cw && !w_empty;
    assign w_push     = bus.mc_valid && bus.mc_ready;
    assign w_issue_ok = bus.mc_issue && !w_stall && bus.mc_issue_rd != 5'd0;

    always_comb begin
        w_we   = 1'b0;
        w_addr = 5'd0;
        w_data = '0;
        if (w_cw) begin
            w_we   = 1'b1;
            w_addr = bus.core_rd;
            w_data = bus.core_data;
        end else if (w_pop) begin
            w_we   = (w_head_rd != 5'd0);
            w_addr = w_head_rd;
            w_data = w_head_data;
        end
    end

    // Issue and drain never collide on one register: issuing to a busy rd stalls.
    always_comb begin
        w_busy_next = r_busy;
        if (w_pop && w_head_rd != 5'd0) w_busy_next[w_head_rd] = 1'b0;
        if (w_issue_ok) w_busy_next[bus.mc_issue_rd] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy       <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_empty || w_pop)
                r_starve_cnt <= '0;
            else if (!w_starve)
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_buf_rd[r_wr_ptr]   <= bus.mc_rd;
            r_buf_data[r_wr_ptr] <= bus.mc_data;
        end
    end

    assign bus.mc_ready      = !w_full && !reset;
    assign bus.stall         = w_stall;
    assign bus.rf_reg_write  = w_we;
    assign bus.rf_rd_address = w_addr;
    assign bus.rf_write_data = w_data;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler. It covers reset, issue/return, write-port conflict, starvation,
// a full buffer, x0 results, WAW hazards, issue gating and a reset in the middle of operation.
module tb_regfile_wb_scheduler;
    logic clock;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    regfile_wb_if #(.XLEN(64)) bus ();

    regfile_wb_scheduler #(.XLEN(64), .DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.core_write  = 1'b0;
        bus.core_rd     = 5'd0;
        bus.core_data   = '0;
        bus.mc_issue    = 1'b0;
        bus.mc_issue_rd = 5'd0;
        bus.mc_valid    = 1'b0;
        bus.mc_rd       = 5'd0;
        bus.mc_data     = '0;
        bus.rs1_address = 5'd0;
        bus.rs2_address = 5'd0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic core_wr(input logic [4:0] rd, input logic [63:0] d);
        bus.core_write = 1'b1;
        bus.core_rd    = rd;
        bus.core_data  = d;
    endtask

    task automatic mc_ret(input logic [4:0] rd, input logic [63:0] d);
        bus.mc_valid = 1'b1;
        bus.mc_rd    = rd;
        bus.mc_data  = d;
    endtask

    task automatic chk_wp(input string tag, input logic we, input logic [4:0] a, input logic [63:0] d);
        chk({tag, "_we"},   bus.rf_reg_write,  we);
        chk({tag, "_addr"}, bus.rf_rd_address, a);
        chk({tag, "_data"}, bus.rf_write_data, d);
    endtask

    initial begin
        // Reset with pending requests: everything quiet and nothing pushed
        reset = 1'b1;
        idle();
        core_wr(5'd3, 64'h33);
        mc_ret(5'd4, 64'h44);
        #1;
        chk("rst_pre_stall", bus.stall, 1'b0);
        chk_wp("rst_pre", 1'b0, 5'd0, 64'h0);
        chk("rst_pre_ready", bus.mc_ready, 1'b0);
        tick();
        chk("rst_post_stall", bus.stall, 1'b0);
        chk_wp("rst_post", 1'b0, 5'd0, 64'h0);
        chk("rst_post_ready", bus.mc_ready, 1'b0);
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("rel_ready", bus.mc_ready, 1'b1);
        chk_wp("rel_empty", 1'b0, 5'd0, 64'h0);

        // Issue rd=5, then RAW stall until the result is written
        bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd5;
        #1;
        chk("iss_stall", bus.stall, 1'b0);
        tick();
        idle();
        bus.rs1_address = 5'd5;
        #1;
        chk("raw_stall", bus.stall, 1'b1);
        tick();
        mc_ret(5'd5, 64'hDEAD_BEEF);
        #1;
        chk("ret_ready", bus.mc_ready, 1'b1);
        chk("ret_stall", bus.stall, 1'b1);
        chk("ret_we", bus.rf_reg_write, 1'b0);
        tick();
        bus.mc_valid = 1'b0;
        #1;
        chk_wp("ret_head", 1'b1, 5'd5, 64'hDEAD_BEEF);
        chk("ret_head_stall", bus.stall, 1'b1);
        tick();
        chk("ret_clear_stall", bus.stall, 1'b0);
        chk("ret_clear_we", bus.rf_reg_write, 1'b0);

        // Conflict: core writes rd3 three cycles while head {7,0x11} waits
        idle();
        mc_ret(5'd7, 64'h11);
        core_wr(5'd3, 64'h33);
        #1;
        chk_wp("cf_c0", 1'b1, 5'd3, 64'h33);
        tick();
        bus.mc_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            #1;
            chk_wp($sformatf("cf_c%0d", i), 1'b1, 5'd3, 64'h33);
            chk($sformatf("cf_stall%0d", i), bus.stall, 1'b0);
            tick();
        end
        bus.core_write = 1'b0;
        #1;
        chk_wp("cf_drain", 1'b1, 5'd7, 64'h11);
        tick();
        chk("cf_empty_we", bus.rf_reg_write, 1'b0);

        // Starvation: head {8,0x88} under continuous core writes drains on its 5th head cycle
        idle();
        mc_ret(5'd8, 64'h88);
        core_wr(5'd3, 64'h33);
        tick();
        bus.mc_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("sv_stall%0d", i), bus.stall, 1'b0);
            chk($sformatf("sv_addr%0d", i), bus.rf_rd_address, 5'd3);
            tick();
        end
        #1;
        chk("sv_stall5", bus.stall, 1'b1);
        chk_wp("sv_head", 1'b1, 5'd8, 64'h88);
        tick();
        chk("sv_after_stall", bus.stall, 1'b0);
        chk_wp("sv_after", 1'b1, 5'd3, 64'h33);

        // Full buffer: two pushes under core writes, third held until a pop
        idle();
        core_wr(5'd3, 64'h33);
        mc_ret(5'd10, 64'hA);
        tick();
        mc_ret(5'd11, 64'hB);
        #1;
        chk("fb_ready1", bus.mc_ready, 1'b1);
        tick();
        mc_ret(5'd12, 64'hC);
        for (int i = 3; i <= 5; i++) begin
            #1;
            chk($sformatf("fb_ready_c%0d", i), bus.mc_ready, 1'b0);
            chk($sformatf("fb_addr_c%0d", i), bus.rf_rd_address, 5'd3);
            tick();
        end
        #1;
        chk("fb_starve_stall", bus.stall, 1'b1);
        chk("fb_starve_ready", bus.mc_ready, 1'b0);
        chk_wp("fb_pop10", 1'b1, 5'd10, 64'hA);
        tick();
        chk("fb_ready_after", bus.mc_ready, 1'b1);
        chk_wp("fb_core", 1'b1, 5'd3, 64'h33);
        tick();
        idle();
        #1;
        chk_wp("fb_pop11", 1'b1, 5'd11, 64'hB);
        tick();
        chk_wp("fb_pop12", 1'b1, 5'd12, 64'hC);
        tick();
        chk("fb_empty_we", bus.rf_reg_write, 1'b0);

        // x0 result and WAW on busy rd9, with an issue gated by the stall
        bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd9;
        tick();
        idle();
        core_wr(5'd9, 64'h999);
        mc_ret(5'd0, 64'h55);
        bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd14;
        #1;
        chk("waw_stall", bus.stall, 1'b1);
        chk("waw_we", bus.rf_reg_write, 1'b0);
        tick();
        bus.mc_valid = 1'b0;
        bus.mc_issue = 1'b0;
        #1;
        chk("x0_stall", bus.stall, 1'b1);
        chk_wp("x0_head", 1'b0, 5'd0, 64'h55);
        tick();
        chk_wp("x0_gone", 1'b0, 5'd0, 64'h0);
        idle();
        bus.rs1_address = 5'd14;
        #1;
        chk("gated_issue_stall", bus.stall, 1'b0);
        mc_ret(5'd9, 64'h99);
        tick();
        idle();
        #1;
        chk_wp("r9_head", 1'b1, 5'd9, 64'h99);
        tick();
        core_wr(5'd9, 64'h999);
        #1;
        chk("r9_waw_clear", bus.stall, 1'b0);
        chk_wp("r9_core", 1'b1, 5'd9, 64'h999);

        // Reset mid-operation drops busy bits and buffered results
        idle();
        bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd12;
        tick();
        idle();
        core_wr(5'd3, 64'h33);
        mc_ret(5'd13, 64'h77);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.rs1_address = 5'd12;
        #1;
        chk("mr_stall", bus.stall, 1'b0);
        chk_wp("mr_empty", 1'b0, 5'd0, 64'h0);
        chk("mr_ready", bus.mc_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
